// File: rtl/serial_pkg.sv
// serial_pkg
//   Shared definitions for the asynchronous serial receive path:
//   FSM state encoding and default frame geometry.
package serial_pkg;

    localparam int SERIAL_DEFAULT_WIDTH        = 8;
    localparam int SERIAL_DEFAULT_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchroniser for a single asynchronous input. Its reset value is
//   a parameter so that idle-high lines do not glitch low out of reset.
// Ports:
//   clk    in  destination clock
//   rst_n  in  asynchronous active-low reset
//   d      in  asynchronous input
//   q      out synchronised output (two clk cycles of latency)
module sync_2ff #(
    parameter bit RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_byte_receiver.sv
// serial_byte_receiver
//   8N1-style asynchronous serial receiver with a fixed oversampling count.
//   Correct frames load `data` and pulse `data_valid` for one cycle; a low
//   stop bit pulses `frame_err` and leaves `data` untouched.
//   Optional feature macro: SERIAL_RX_PARITY_EN adds an even-parity bit
//   before the stop bit and the `parity_err` output.
// Ports:
//   clk         in  system clock
//   rst_n       in  asynchronous active-low reset
//   rx          in  serial line, idle high, asynchronous to clk
//   data        out last correctly received word, LSB = first data bit
//   data_valid  out one-cycle pulse when data has just been updated
//   frame_err   out one-cycle pulse when the stop bit was sampled low
//   parity_err  out one-cycle pulse on parity mismatch (SERIAL_RX_PARITY_EN only)
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | line idle, waiting for a low level (candidate start bit)
// START     | half a bit in, confirm the start bit or reject a glitch
// DATA      | sample one data bit per bit period, LSB first
// PARITY    | sample the even-parity bit (SERIAL_RX_PARITY_EN only)
// STOP      | sample the stop bit, publish the word or flag an error
// WAIT_IDLE | after a framing error, wait for the line to return high
module serial_byte_receiver
    import serial_pkg::*;
#(
    parameter int WIDTH        = SERIAL_DEFAULT_WIDTH,
    parameter int CLKS_PER_BIT = SERIAL_DEFAULT_CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    output logic             frame_err
`ifdef SERIAL_RX_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

    logic             rx_s;
    rx_state_t        state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [IW-1:0]    bit_idx, bit_nx;
    logic [WIDTH-1:0] shift_q, shift_nx;
    logic [WIDTH-1:0] data_nx;
    logic             dv_nx, fe_nx;
`ifdef SERIAL_RX_PARITY_EN
    logic             par_q, par_nx;
    logic             pe_nx;
`endif

    sync_2ff #(.RST_VAL(1'b1)) u_sync_rx (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift_q    <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_q      <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            bit_idx    <= bit_nx;
            shift_q    <= shift_nx;
            data       <= data_nx;
            data_valid <= dv_nx;
            frame_err  <= fe_nx;
`ifdef SERIAL_RX_PARITY_EN
            par_q      <= par_nx;
            parity_err <= pe_nx;
`endif
        end
    end

    // The counter free-runs inside a state and is cleared on every sample
    // point / state change, so each bit period restarts from zero.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        bit_nx   = bit_idx;
        shift_nx = shift_q;
        data_nx  = data;
        dv_nx    = 1'b0;
        fe_nx    = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        par_nx   = par_q;
        pe_nx    = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (!rx_s) state_nx = START;
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_nx   = '0;
                    bit_nx   = '0;
                    state_nx = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_nx   = '0;
                    shift_nx = {rx_s, shift_q[WIDTH-1:1]};
                    bit_nx   = bit_idx + 1'b1;
                    if (bit_idx == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                if (cnt == FULL_M1) begin
                    cnt_nx   = '0;
                    par_nx   = rx_s;
                    state_nx = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_nx = '0;
                    if (!rx_s) begin
                        fe_nx    = 1'b1;
                        state_nx = WAIT_IDLE;
                    end else begin
                        state_nx = IDLE;
`ifdef SERIAL_RX_PARITY_EN
                        // Even parity: data bits plus parity bit hold an even count of ones.
                        if ((^shift_q) ^ par_q) begin
                            pe_nx = 1'b1;
                        end else begin
                            data_nx = shift_q;
                            dv_nx   = 1'b1;
                        end
`else
                        data_nx = shift_q;
                        dv_nx   = 1'b1;
`endif
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_nx = '0;
                if (rx_s) state_nx = IDLE;
            end
            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

endmodule
